// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect,
// decode handoff and status.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] stall_cycles;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
               fetch_fault, fault_pc, stall_cycles,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
               fetch_fault, fault_pc, stall_cycles,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, credit-limited memory requests, response FIFO
// and redirect flush. Define FETCH_STALL_CNT_EN to build the stall_cycles counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;
    logic [31:0]   hold_data_q, hold_data_d, hold_pc_q, hold_pc_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
    logic [31:0]   mem_data_q [FIFO_DEPTH];
    logic [31:0]   mem_pc_q   [FIFO_DEPTH];

    logic          req_valid, req_fire, rsp_fire, push, pop, fifo_nonempty;
    logic [AW-1:0] wr_idx, rd_idx;

    assign fifo_count    = wr_ptr_q - rd_ptr_q;
    assign fifo_nonempty = (fifo_count != '0);
    assign wr_idx        = wr_ptr_q[AW-1:0];
    assign rd_idx        = rd_ptr_q[AW-1:0];

    // Every outstanding request already owns a FIFO slot, so responses never overflow.
    assign req_valid = rst_n && (state_q == ST_RUN) && !bus.redirect_valid &&
                       (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_L);
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_fire  = bus.imem_rsp_valid && (outstanding_q != '0);
    assign push      = rsp_fire && (drop_cnt_q == '0) && !bus.redirect_valid;
    assign pop       = fifo_nonempty && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d    = drop_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        hold_data_d   = hold_data_q;
        hold_pc_d     = hold_pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old path and gets dropped.
            outstanding_d = outstanding_q - CW'(rsp_fire);
            drop_cnt_d    = outstanding_q - CW'(rsp_fire);
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            pc_d          = bus.redirect_pc;
            rsp_pc_d      = bus.redirect_pc;
            hold_data_d   = NOP;
            hold_pc_d     = RESET_PC;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d    = ST_HALT;
                fault_d    = 1'b1;
                fault_pc_d = bus.redirect_pc;
            end else begin
                state_d    = ST_RUN;
                fault_d    = 1'b0;
                fault_pc_d = '0;
            end
        end else begin
            if (req_fire)
                pc_d = pc_q + 32'd4;
            if (rsp_fire && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - 1'b1;
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                hold_data_d = mem_data_q[rd_idx];
                hold_pc_d   = mem_pc_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            hold_data_q   <= NOP;
            hold_pc_q     <= RESET_PC;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            hold_data_q   <= hold_data_d;
            hold_pc_q     <= hold_pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_idx] <= bus.imem_rsp_data;
            mem_pc_q[wr_idx]   <= rsp_pc_q;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = fifo_nonempty;
    assign bus.inst_data      = fifo_nonempty ? mem_data_q[rd_idx] : hold_data_q;
    assign bus.inst_pc        = fifo_nonempty ? mem_pc_q[rd_idx]   : hold_pc_q;
    assign bus.fetch_fault    = fault_q;
    assign bus.fault_pc       = fault_pc_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if ((state_q == ST_RUN) && !fifo_nonempty && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end
    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

`ifndef SYNTHESIS
    rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (outstanding_q != '0));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus an instruction-stream
// reference (expected PC sequence, buffered count, fault state, stall count).
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        mem_q[$];
    int          total = 0, bad = 0;
    int          cyc = 0, epoch = 0, last_due = 0;
    int          rdy_pct = 100, ird_pct = 100, lat_lo = 1, lat_hi = 1;
    int          occ = 0, fires = 0;
    bit          halted = 0, last_iv = 0, last_rv = 0;
    logic [31:0] exp_pc, exp_req, fault_addr, hold_pc, hold_data, exp_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_req_addr", bus.imem_req_addr, 32'h0);
        check_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rst_inst_data", bus.inst_data, NOP);
        check_eq("rst_inst_pc", bus.inst_pc, 32'h0);
        check_eq("rst_fault", 32'(bus.fetch_fault), 32'd0);
        check_eq("rst_fault_pc", bus.fault_pc, 32'h0);
        check_eq("rst_stall", bus.stall_cycles, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_q.delete();
        occ = 0; halted = 0; last_due = 0; epoch++;
        exp_pc = 32'h0; exp_req = 32'h0; hold_pc = 32'h0; hold_data = NOP; exp_stall = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic run_cycle(input bit redir, input logic [31:0] tgt);
        bit   rsp_drv, iv_exp, rv_exp, req_fire, inst_fire;
        req_t r;
        int   due;
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        rsp_drv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = rsp_drv;
        if (rsp_drv) bus.imem_rsp_data = mem_q[0].addr ^ KEY;
        else         bus.imem_rsp_data = $urandom;
        bus.inst_ready     = ($urandom_range(99) < ird_pct);
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        @(negedge clk);
        iv_exp = (occ > 0);
        rv_exp = !halted && !redir && ((mem_q.size() + occ) < DEPTH);
        check_eq("inst_valid", 32'(bus.inst_valid), 32'(iv_exp));
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(rv_exp));
        if (rv_exp) check_eq("req_addr", bus.imem_req_addr, exp_req);
        if (!iv_exp) begin
            check_eq("idle_inst_pc", bus.inst_pc, hold_pc);
            check_eq("idle_inst_data", bus.inst_data, hold_data);
        end
        check_eq("fetch_fault", 32'(bus.fetch_fault), 32'(halted));
        if (halted) check_eq("fault_pc", bus.fault_pc, fault_addr);
`ifdef FETCH_STALL_CNT_EN
        check_eq("stall_cycles", bus.stall_cycles, exp_stall);
`else
        check_eq("stall_cycles", bus.stall_cycles, 32'h0);
`endif
        last_iv = bus.inst_valid;
        last_rv = bus.imem_req_valid;
        if (!halted && !iv_exp) exp_stall++;
        req_fire  = rv_exp && bus.imem_req_ready;
        inst_fire = iv_exp && bus.inst_ready && !redir;
        if (redir) begin
            if (rsp_drv) void'(mem_q.pop_front());
            occ = 0; epoch++;
            hold_pc = 32'h0; hold_data = NOP;
            halted = (tgt[1:0] != 2'b00);
            if (halted) fault_addr = tgt;
            else begin exp_pc = tgt; exp_req = tgt; end
        end else begin
            if (inst_fire) begin
                check_eq("inst_pc", bus.inst_pc, exp_pc);
                check_eq("inst_data", bus.inst_data, exp_pc ^ KEY);
                $display("inst pc=%08h data=%08h cycle=%0d", bus.inst_pc, bus.inst_data, cyc);
                hold_pc = exp_pc; hold_data = exp_pc ^ KEY;
                exp_pc += 32'd4; occ--; fires++;
            end
            if (req_fire) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due < last_due) due = last_due;
                last_due = due;
                r.addr = exp_req; r.due = due; r.epoch = epoch;
                mem_q.push_back(r);
                exp_req += 32'd4;
            end
            if (rsp_drv) begin
                r = mem_q.pop_front();
                if (r.epoch == epoch) occ++;
            end
        end
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0);
    endtask

    int lat_seen;
    int fires0;

    initial begin
        do_reset();

        // Steady stream, 1-cycle memory; the credit rule allows 2 of every 3 cycles.
        run_n(10);
        fires0 = fires;
        run_n(30);
        check_eq("throughput", 32'(fires - fires0), 32'd20);

        // Redirect to first valid instruction takes three cycles.
        run_cycle(1'b1, 32'h0000_0180);
        lat_seen = 0;
        for (int k = 1; k <= 8 && lat_seen == 0; k++) begin
            run_cycle(1'b0, 32'h0);
            if (last_iv) lat_seen = k;
        end
        check_eq("redirect_latency", 32'(lat_seen), 32'd3);
        run_n(6);

        // Backpressure fills the buffer and then blocks requests.
        ird_pct = 0;
        run_n(10);
        check_eq("bp_req_blocked", 32'(last_rv), 32'd0);
        check_eq("bp_head_valid", 32'(last_iv), 32'd1);
        ird_pct = 100;
        run_n(10);

        // Slow memory: redirect with requests in flight, stale data must vanish.
        lat_lo = 3; lat_hi = 3;
        run_n(6);
        run_cycle(1'b1, 32'h0000_0100);
        lat_lo = 1; lat_hi = 1;
        run_n(12);

        // Misaligned redirect halts fetch until an aligned one arrives.
        run_cycle(1'b1, 32'h0000_0102);
        run_n(5);
        check_eq("halt_fault", 32'(bus.fetch_fault), 32'd1);
        check_eq("halt_fault_pc", bus.fault_pc, 32'h0000_0102);
        run_cycle(1'b1, 32'h0000_0200);
        run_n(10);

        // Address wrap at the top of memory.
        run_cycle(1'b1, 32'hFFFF_FFF8);
        run_n(10);

        // Memory stalled right after reset.
        do_reset();
        rdy_pct = 0;
        run_n(5);
        rdy_pct = 100;
        run_n(10);

        // Random traffic with occasional redirects.
        rdy_pct = 70; ird_pct = 60; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) begin
                case ($urandom_range(4))
                    0:       run_cycle(1'b1, $urandom | 32'h1);
                    1:       run_cycle(1'b1, 32'hFFFF_FFF0 | ($urandom & 32'hC));
                    default: run_cycle(1'b1, $urandom & 32'hFFFF_FFFC);
                endcase
            end else begin
                run_cycle(1'b0, 32'h0);
            end
        end
        run_cycle(1'b1, 32'h0000_0400);
        run_n(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
